pcs_synchronize: RTL and testbench
==================================

PCS_SYNCHRONIZE -- requirements
Module: pcs_synchronize

Interface
REQ-001 SHALL provide port GTX_CLK  in  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL provide port mr_main_reset  in  1  reset, synchronous and active-high.
REQ-003 SHALL provide port rx_code_group  in  10  received code-group from the downstream link; bit 9 = 'a', bit 0 = 'j'.
REQ-004 SHALL provide port signal_detect  in  1  PMD signal present; low forces loss of sync.
REQ-005 SHALL provide port code_sync_status  out  1  1 = OK, 0 = FAIL.
REQ-006 SHALL provide port rx_even  out  1  even/odd code-group alignment flag.
REQ-007 SHALL provide port SUDI_code_group  out  10  rx_code_group delayed one cycle, aligned with rx_even and code_sync_status.
REQ-008 SHALL provide port SUDI_valid  out  1  1 when SUDI_code_group is a valid code-group.
REQ-009 SHALL provide port loss_cnt  out  8  loss-of-sync event count, present only under SYNC_LOSS_CNT_EN.

Function
REQ-010 SHALL detect comma when rx_code_group[9:3] equals 0011111 or 1100000.
REQ-011 SHALL flag cgbad when the code-group is invalid per Clause 36 8B/10B tables for the current running disparity, or when a comma arrives while rx_even = 1; otherwise the code-group is cggood.
REQ-012 SHALL track running disparity: reset to negative; update per 6b and 4b sub-block on every code-group, including invalid ones.
REQ-013 SHALL implement states LOSS_OF_SYNC, COMMA_DETECT_1..3, ACQUIRE_SYNC_1..2, SYNC_ACQUIRED_1, 2, 2A, 3, 3A, 4, 4A.
REQ-014 SHALL, in LOSS_OF_SYNC: code_sync_status = 0; toggle rx_even every cycle; go to COMMA_DETECT_1 on comma with signal_detect = 1.
REQ-015 SHALL, in COMMA_DETECT_n: set rx_even = 1; go to ACQUIRE_SYNC_n (n = 1, 2) or SYNC_ACQUIRED_1 (n = 3) on a valid /D/; otherwise go to LOSS_OF_SYNC.
REQ-016 SHALL, in ACQUIRE_SYNC_n: toggle rx_even; cgbad -> LOSS_OF_SYNC; comma with rx_even = 0 -> COMMA_DETECT_n+1; otherwise stay.
REQ-017 SHALL, in SYNC_ACQUIRED_1: code_sync_status = 1; toggle rx_even; cgbad -> SYNC_ACQUIRED_2.
REQ-018 SHALL, in SYNC_ACQUIRED_k (k = 2, 3, 4): clear good_cgs; cgbad -> SYNC_ACQUIRED_k+1 (k = 4: LOSS_OF_SYNC); cggood -> SYNC_ACQUIRED_kA with good_cgs = 1.
REQ-019 SHALL, in SYNC_ACQUIRED_kA: increment good_cgs on cggood; good_cgs = 3 with cggood -> SYNC_ACQUIRED_k-1 (2A: SYNC_ACQUIRED_1); cgbad -> SYNC_ACQUIRED_k+1 (4A: LOSS_OF_SYNC).
REQ-020 SHALL use a 2-bit good_cgs counter; it never wraps because it is consumed at 3.
REQ-021 SHALL, with signal_detect = 0 in any state, go to LOSS_OF_SYNC on the next edge; this takes priority over all other transitions.
REQ-022 SHALL register all outputs; a code-group sampled at edge N is reflected in the outputs after edge N+1 (latency 1).

Reset
REQ-023 SHALL, with mr_main_reset = 1 at a rising edge: state = LOSS_OF_SYNC, code_sync_status = 0, rx_even = 0, SUDI_code_group = 0, SUDI_valid = 0, running disparity negative, good_cgs = 0.
REQ-024 SHALL treat reset asserted mid-operation, including in SYNC_ACQUIRED_*, as REQ-023; loss_cnt is cleared and reset does not count as a loss event.

Configuration
REQ-025 SHALL, with SYNC_LOSS_CNT_EN defined: instantiate loss_cnt, incrementing on each transition from code_sync_status 1 to 0 and saturating at 255.
REQ-026 SHALL, with SYNC_LOSS_CNT_EN undefined: omit the loss_cnt port and logic; all other behaviour is identical.

Structure
REQ-027 SHALL keep in a shared package: the state encoding constants, the K28.5 patterns (0x0FA, 0x305), comma masks, and the good_cgs limit (3).
REQ-028 SHALL place the validity and disparity check in one combinational sub-module, pcs_cg_check (inputs: code-group, RD; outputs: valid, is_comma, is_data, next RD).

Verification
REQ-029 SHALL verify acquisition: after reset, repeat /I2/ (0x0FA, 0x245) -> code_sync_status = 1 one cycle after the 3rd comma's following /D/, with rx_even = 1 on every comma.
REQ-030 SHALL verify isolated errors: in sync, inject 1 invalid code-group (0x000) followed by 4 /I2/ words -> status stays 1 and state returns to SYNC_ACQUIRED_1.
REQ-031 SHALL verify loss on errors: in sync, inject 4 consecutive 0x000 -> code_sync_status = 0 after the 4th; loss_cnt = 1 under SYNC_LOSS_CNT_EN.
REQ-032 SHALL verify signal_detect drop: in sync, drive signal_detect = 0 for 1 cycle -> LOSS_OF_SYNC, code_sync_status = 0 next cycle.
REQ-033 SHALL verify odd comma: during ACQUIRE_SYNC_1, place 0x0FA where rx_even = 1 -> return to LOSS_OF_SYNC.
REQ-034 SHALL verify reset mid-sync: assert mr_main_reset for 1 cycle while in SYNC_ACQUIRED_1 -> all outputs equal the REQ-023 values on the next cycle.

Source files
------------

// File: rtl/pcs_synchronize_pkg.sv
// Shared constants for the 1000BASE-X PCS code-group synchronization block:
// state encoding, K28.5 patterns, comma masks and the good code-group limit.
package pcs_synchronize_pkg;

    typedef enum logic [3:0] {
        LOSS_OF_SYNC     = 4'd0,
        COMMA_DETECT_1   = 4'd1,
        COMMA_DETECT_2   = 4'd2,
        COMMA_DETECT_3   = 4'd3,
        ACQUIRE_SYNC_1   = 4'd4,
        ACQUIRE_SYNC_2   = 4'd5,
        SYNC_ACQUIRED_1  = 4'd6,
        SYNC_ACQUIRED_2  = 4'd7,
        SYNC_ACQUIRED_2A = 4'd8,
        SYNC_ACQUIRED_3  = 4'd9,
        SYNC_ACQUIRED_3A = 4'd10,
        SYNC_ACQUIRED_4  = 4'd11,
        SYNC_ACQUIRED_4A = 4'd12
    } sync_state_t;

    localparam logic [9:0] K28_5_NEG     = 10'h0FA;
    localparam logic [9:0] K28_5_POS     = 10'h305;
    localparam logic [9:0] COMMA_MASK    = 10'b1111111000;
    localparam logic [9:0] COMMA_NEG_PAT = 10'b0011111000;
    localparam logic [9:0] COMMA_POS_PAT = 10'b1100000000;

    localparam logic [1:0] GOOD_CGS_LIMIT = 2'd3;

    function automatic logic is_comma_cg(input logic [9:0] cg);
        return ((cg & COMMA_MASK) == COMMA_NEG_PAT) || ((cg & COMMA_MASK) == COMMA_POS_PAT);
    endfunction

endpackage

// File: rtl/pcs_synchronize_cg_check.sv
// Combinational 8B/10B code-group check: validity against the current running
// disparity, comma/data classification and the running disparity that follows.
module pcs_cg_check
    import pcs_synchronize_pkg::*;
(
    input  logic [9:0] code_group,
    input  logic       rd,
    output logic       valid,
    output logic       is_comma,
    output logic       is_data,
    output logic       rd_next
);

    logic [5:0] sb6;
    logic [3:0] sb4;
    logic [2:0] ones6;
    logic [2:0] ones4;
    logic       rd_mid;
    logic       v6;
    logic       v4;
    logic       alt_ok;
    logic       is_k;
    logic       a7_lo;
    logic       a7_hi;
    logic       kx7_lo;
    logic       kx7_hi;

    assign sb6 = code_group[9:4];
    assign sb4 = code_group[3:0];

    // 6b sub-blocks that must (D.17/18/20, D.11/13/14) or may (K23/27/29/30) take the alternate x.7
    assign a7_lo  = sb6 inside {6'b100011, 6'b010011, 6'b001011};
    assign a7_hi  = sb6 inside {6'b110100, 6'b101100, 6'b011100};
    assign kx7_lo = sb6 inside {6'b000101, 6'b001001, 6'b010001, 6'b100001};
    assign kx7_hi = sb6 inside {6'b111010, 6'b110110, 6'b101110, 6'b011110};

    always_comb begin
        ones6 = 3'd0;
        for (int i = 0; i < 6; i++) ones6 = ones6 + {2'b00, sb6[i]};
        ones4 = 3'd0;
        for (int i = 0; i < 4; i++) ones4 = ones4 + {2'b00, sb4[i]};

        v6 = 1'b0;
        if (ones6 == 3'd4)      v6 = !rd && (sb6 != 6'b111100);
        else if (ones6 == 3'd2) v6 = rd && (sb6 != 6'b000011);
        else if (ones6 == 3'd3) begin
            if (sb6 == 6'b111000)      v6 = !rd;
            else if (sb6 == 6'b000111) v6 = rd;
            else                       v6 = 1'b1;
        end

        if (ones6 > 3'd3)            rd_mid = 1'b1;
        else if (ones6 < 3'd3)       rd_mid = 1'b0;
        else if (sb6 == 6'b000111)   rd_mid = 1'b1;
        else if (sb6 == 6'b111000)   rd_mid = 1'b0;
        else                         rd_mid = rd;

        v4 = 1'b0;
        if (ones4 == 3'd3)      v4 = !rd_mid;
        else if (ones4 == 3'd1) v4 = rd_mid;
        else if (ones4 == 3'd2) begin
            if (sb4 == 4'b1100)      v4 = !rd_mid;
            else if (sb4 == 4'b0011) v4 = rd_mid;
            else                     v4 = 1'b1;
        end

        if (ones4 > 3'd2)          rd_next = 1'b1;
        else if (ones4 < 3'd2)     rd_next = 1'b0;
        else if (sb4 == 4'b0011)   rd_next = 1'b1;
        else if (sb4 == 4'b1100)   rd_next = 1'b0;
        else                       rd_next = rd_mid;

        case (sb4)
            4'b0111: alt_ok = a7_lo || kx7_lo || (sb6 == 6'b110000);
            4'b1000: alt_ok = a7_hi || kx7_hi || (sb6 == 6'b001111);
            4'b1110: alt_ok = !(a7_lo || (sb6 == 6'b110000));
            4'b0001: alt_ok = !(a7_hi || (sb6 == 6'b001111));
            default: alt_ok = 1'b1;
        endcase
    end

    assign is_k = (sb6 == 6'b001111) || (sb6 == 6'b110000)
               || (kx7_lo && (sb4 == 4'b0111)) || (kx7_hi && (sb4 == 4'b1000));

    assign valid    = v6 && v4 && alt_ok;
    assign is_data  = valid && !is_k;
    assign is_comma = is_comma_cg(code_group);

endmodule

// File: rtl/pcs_synchronize.sv
// PCS receive code-group synchronization state machine (1000BASE-X style).
// Optional loss-of-sync event counter enabled by defining SYNC_LOSS_CNT_EN.
//
// state            | meaning
// LOSS_OF_SYNC     | no alignment, rx_even free-running
// COMMA_DETECT_n   | n-th comma seen on an even boundary, expect /D/
// ACQUIRE_SYNC_n   | hunting for comma n+1 on an even boundary
// SYNC_ACQUIRED_1  | in sync, no outstanding errors
// SYNC_ACQUIRED_k  | in sync, k-1 outstanding errors
// SYNC_ACQUIRED_kA | in sync, counting good code-groups to retire one error
module pcs_synchronize
    import pcs_synchronize_pkg::*;
(
    input  logic       GTX_CLK,
    input  logic       mr_main_reset,
    input  logic [9:0] rx_code_group,
    input  logic       signal_detect,
    output logic       code_sync_status,
    output logic       rx_even,
    output logic [9:0] SUDI_code_group,
    output logic       SUDI_valid
`ifdef SYNC_LOSS_CNT_EN
    ,
    output logic [7:0] loss_cnt
`endif
);

    sync_state_t state;
    logic        rd;
    logic [1:0]  good_cgs;
    logic        cg_valid;
    logic        cg_comma;
    logic        cg_data;
    logic        rd_next;
    logic        cgbad;

    pcs_cg_check u_cg_check (
        .code_group (rx_code_group),
        .rd         (rd),
        .valid      (cg_valid),
        .is_comma   (cg_comma),
        .is_data    (cg_data),
        .rd_next    (rd_next)
    );

    // a comma landing on an odd position means alignment has slipped
    assign cgbad = !cg_valid || (cg_comma && rx_even);

    always_ff @(posedge GTX_CLK) begin
        if (mr_main_reset) begin
            state            <= LOSS_OF_SYNC;
            code_sync_status <= 1'b0;
            rx_even          <= 1'b0;
            SUDI_code_group  <= 10'd0;
            SUDI_valid       <= 1'b0;
            rd               <= 1'b0;
            good_cgs         <= 2'd0;
        end else begin
            SUDI_code_group <= rx_code_group;
            SUDI_valid      <= cg_valid;
            rd              <= rd_next;
            rx_even         <= !rx_even;
            if (!signal_detect) begin
                state            <= LOSS_OF_SYNC;
                code_sync_status <= 1'b0;
                good_cgs         <= 2'd0;
            end else begin
                case (state)
                    LOSS_OF_SYNC: begin
                        if (cg_comma) begin
                            state   <= COMMA_DETECT_1;
                            rx_even <= 1'b1;
                        end
                    end
                    COMMA_DETECT_1: state <= cg_data ? ACQUIRE_SYNC_1 : LOSS_OF_SYNC;
                    COMMA_DETECT_2: state <= cg_data ? ACQUIRE_SYNC_2 : LOSS_OF_SYNC;
                    COMMA_DETECT_3: begin
                        if (cg_data) begin
                            state            <= SYNC_ACQUIRED_1;
                            code_sync_status <= 1'b1;
                        end else begin
                            state <= LOSS_OF_SYNC;
                        end
                    end
                    ACQUIRE_SYNC_1, ACQUIRE_SYNC_2: begin
                        if (cgbad) begin
                            state <= LOSS_OF_SYNC;
                        end else if (cg_comma && !rx_even) begin
                            state   <= (state == ACQUIRE_SYNC_1) ? COMMA_DETECT_2 : COMMA_DETECT_3;
                            rx_even <= 1'b1;
                        end
                    end
                    SYNC_ACQUIRED_1: begin
                        if (cgbad) begin
                            state    <= SYNC_ACQUIRED_2;
                            good_cgs <= 2'd0;
                        end
                    end
                    SYNC_ACQUIRED_2, SYNC_ACQUIRED_3, SYNC_ACQUIRED_4: begin
                        if (cgbad) begin
                            good_cgs <= 2'd0;
                            case (state)
                                SYNC_ACQUIRED_2: state <= SYNC_ACQUIRED_3;
                                SYNC_ACQUIRED_3: state <= SYNC_ACQUIRED_4;
                                default: begin
                                    state            <= LOSS_OF_SYNC;
                                    code_sync_status <= 1'b0;
                                end
                            endcase
                        end else begin
                            good_cgs <= 2'd1;
                            case (state)
                                SYNC_ACQUIRED_2: state <= SYNC_ACQUIRED_2A;
                                SYNC_ACQUIRED_3: state <= SYNC_ACQUIRED_3A;
                                default:         state <= SYNC_ACQUIRED_4A;
                            endcase
                        end
                    end
                    SYNC_ACQUIRED_2A, SYNC_ACQUIRED_3A, SYNC_ACQUIRED_4A: begin
                        if (cgbad) begin
                            good_cgs <= 2'd0;
                            case (state)
                                SYNC_ACQUIRED_2A: state <= SYNC_ACQUIRED_3;
                                SYNC_ACQUIRED_3A: state <= SYNC_ACQUIRED_4;
                                default: begin
                                    state            <= LOSS_OF_SYNC;
                                    code_sync_status <= 1'b0;
                                end
                            endcase
                        end else if (good_cgs == GOOD_CGS_LIMIT) begin
                            good_cgs <= 2'd0;
                            case (state)
                                SYNC_ACQUIRED_2A: state <= SYNC_ACQUIRED_1;
                                SYNC_ACQUIRED_3A: state <= SYNC_ACQUIRED_2;
                                default:          state <= SYNC_ACQUIRED_3;
                            endcase
                        end else begin
                            good_cgs <= good_cgs + 2'd1;
                        end
                    end
                    default: begin
                        state            <= LOSS_OF_SYNC;
                        code_sync_status <= 1'b0;
                        good_cgs         <= 2'd0;
                    end
                endcase
            end
        end
    end

`ifdef SYNC_LOSS_CNT_EN
    logic sync_drop;

    assign sync_drop = code_sync_status && (!signal_detect
                    || (cgbad && (state == SYNC_ACQUIRED_4 || state == SYNC_ACQUIRED_4A)));

    always_ff @(posedge GTX_CLK) begin
        if (mr_main_reset)
            loss_cnt <= 8'd0;
        else if (sync_drop && loss_cnt != 8'hFF)
            loss_cnt <= loss_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_pcs_synchronize.sv
// Self-checking bench for pcs_synchronize: table of code-group vectors with
// hand-derived expectations fed through a scoreboard queue, plus a bounded acquisition check.
module tb_pcs_synchronize;
    import pcs_synchronize_pkg::*;

    logic       GTX_CLK = 1'b0;
    logic       mr_main_reset;
    logic [9:0] rx_code_group;
    logic       signal_detect;
    logic       code_sync_status;
    logic       rx_even;
    logic [9:0] SUDI_code_group;
    logic       SUDI_valid;
`ifdef SYNC_LOSS_CNT_EN
    logic [7:0] loss_cnt;
`endif

    always #5 GTX_CLK = ~GTX_CLK;

    pcs_synchronize dut (
        .GTX_CLK          (GTX_CLK),
        .mr_main_reset    (mr_main_reset),
        .rx_code_group    (rx_code_group),
        .signal_detect    (signal_detect),
        .code_sync_status (code_sync_status),
        .rx_even          (rx_even),
        .SUDI_code_group  (SUDI_code_group),
        .SUDI_valid       (SUDI_valid)
`ifdef SYNC_LOSS_CNT_EN
        ,
        .loss_cnt         (loss_cnt)
`endif
    );

    typedef struct {
        logic [9:0]  cg;
        logic        sd;
        logic        rst;
        logic        status;
        logic        even;
        sync_state_t st;
        logic        valid;
        logic [7:0]  loss;
    } vec_t;

    typedef struct {
        logic [9:0]  sudi;
        logic        status;
        logic        even;
        sync_state_t st;
        logic        valid;
        logic [7:0]  loss;
    } exp_t;

    localparam logic [9:0] D16_2 = 10'h245;
    localparam logic [9:0] D21_5 = 10'h2AA;
    localparam logic [9:0] BADCG = 10'h000;

    vec_t vecs[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(logic [9:0] cg, logic sd, logic rst, logic status,
                                logic even, sync_state_t st, logic valid, logic [7:0] loss);
        vec_t v;
        v.cg = cg; v.sd = sd; v.rst = rst; v.status = status;
        v.even = even; v.st = st; v.valid = valid; v.loss = loss;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic acquire(input logic [7:0] loss);
        vecs.push_back(mk(K28_5_NEG, 1, 0, 0, 1, COMMA_DETECT_1,  1, loss));
        vecs.push_back(mk(D16_2,     1, 0, 0, 0, ACQUIRE_SYNC_1,  1, loss));
        vecs.push_back(mk(K28_5_NEG, 1, 0, 0, 1, COMMA_DETECT_2,  1, loss));
        vecs.push_back(mk(D16_2,     1, 0, 0, 0, ACQUIRE_SYNC_2,  1, loss));
        vecs.push_back(mk(K28_5_NEG, 1, 0, 0, 1, COMMA_DETECT_3,  1, loss));
        vecs.push_back(mk(D16_2,     1, 0, 1, 0, SYNC_ACQUIRED_1, 1, loss));
    endtask

    initial begin
        exp_t e;
        int   n;
        bit   found;

        mr_main_reset = 1'b1;
        rx_code_group = 10'd0;
        signal_detect = 1'b1;

        vecs.push_back(mk(K28_5_NEG, 1, 1, 0, 0, LOSS_OF_SYNC, 0, 0));
        vecs.push_back(mk(K28_5_NEG, 1, 1, 0, 0, LOSS_OF_SYNC, 0, 0));
        acquire(0);
        vecs.push_back(mk(K28_5_NEG, 1, 0, 1, 1, SYNC_ACQUIRED_1,  1, 0));
        vecs.push_back(mk(D16_2,     1, 0, 1, 0, SYNC_ACQUIRED_1,  1, 0));
        // isolated error replacing a /D/, then four good code-groups
        vecs.push_back(mk(K28_5_NEG, 1, 0, 1, 1, SYNC_ACQUIRED_1,  1, 0));
        vecs.push_back(mk(BADCG,     1, 0, 1, 0, SYNC_ACQUIRED_2,  0, 0));
        vecs.push_back(mk(K28_5_NEG, 1, 0, 1, 1, SYNC_ACQUIRED_2A, 1, 0));
        vecs.push_back(mk(D16_2,     1, 0, 1, 0, SYNC_ACQUIRED_2A, 1, 0));
        vecs.push_back(mk(K28_5_NEG, 1, 0, 1, 1, SYNC_ACQUIRED_2A, 1, 0));
        vecs.push_back(mk(D16_2,     1, 0, 1, 0, SYNC_ACQUIRED_1,  1, 0));
        // four consecutive errors
        vecs.push_back(mk(BADCG,     1, 0, 1, 1, SYNC_ACQUIRED_2,  0, 0));
        vecs.push_back(mk(BADCG,     1, 0, 1, 0, SYNC_ACQUIRED_3,  0, 0));
        vecs.push_back(mk(BADCG,     1, 0, 1, 1, SYNC_ACQUIRED_4,  0, 0));
        vecs.push_back(mk(BADCG,     1, 0, 0, 0, LOSS_OF_SYNC,     0, 1));
        acquire(1);
        // signal_detect drop for one cycle
        vecs.push_back(mk(K28_5_NEG, 1, 0, 1, 1, SYNC_ACQUIRED_1,  1, 1));
        vecs.push_back(mk(D16_2,     0, 0, 0, 0, LOSS_OF_SYNC,     1, 2));
        // odd comma during ACQUIRE_SYNC_1
        vecs.push_back(mk(K28_5_NEG, 1, 0, 0, 1, COMMA_DETECT_1,   1, 2));
        vecs.push_back(mk(D16_2,     1, 0, 0, 0, ACQUIRE_SYNC_1,   1, 2));
        vecs.push_back(mk(D21_5,     1, 0, 0, 1, ACQUIRE_SYNC_1,   1, 2));
        vecs.push_back(mk(K28_5_NEG, 1, 0, 0, 0, LOSS_OF_SYNC,     1, 2));
        vecs.push_back(mk(D16_2,     1, 0, 0, 1, LOSS_OF_SYNC,     1, 2));
        vecs.push_back(mk(K28_5_NEG, 0, 0, 0, 0, LOSS_OF_SYNC,     1, 2));
        // positive-disparity comma starts acquisition
        vecs.push_back(mk(K28_5_POS, 1, 0, 0, 1, COMMA_DETECT_1,   1, 2));
        vecs.push_back(mk(D21_5,     1, 0, 0, 0, ACQUIRE_SYNC_1,   1, 2));
        vecs.push_back(mk(K28_5_NEG, 1, 0, 0, 1, COMMA_DETECT_2,   1, 2));
        vecs.push_back(mk(D16_2,     1, 0, 0, 0, ACQUIRE_SYNC_2,   1, 2));
        vecs.push_back(mk(K28_5_NEG, 1, 0, 0, 1, COMMA_DETECT_3,   1, 2));
        vecs.push_back(mk(D16_2,     1, 0, 1, 0, SYNC_ACQUIRED_1,  1, 2));
        // reset while in sync
        vecs.push_back(mk(K28_5_NEG, 1, 1, 0, 0, LOSS_OF_SYNC,     0, 0));
        vecs.push_back(mk(K28_5_NEG, 1, 0, 0, 1, COMMA_DETECT_1,   1, 0));
        vecs.push_back(mk(K28_5_NEG, 1, 0, 0, 0, LOSS_OF_SYNC,     0, 0));
        vecs.push_back(mk(K28_5_POS, 1, 0, 0, 1, COMMA_DETECT_1,   1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge GTX_CLK);
            rx_code_group = vecs[i].cg;
            signal_detect = vecs[i].sd;
            mr_main_reset = vecs[i].rst;
            e.sudi   = vecs[i].rst ? 10'd0 : vecs[i].cg;
            e.status = vecs[i].status;
            e.even   = vecs[i].even;
            e.st     = vecs[i].st;
            e.valid  = vecs[i].valid;
            e.loss   = vecs[i].loss;
            sb.push_back(e);
            @(posedge GTX_CLK);
            #1;
            e = sb.pop_front();
            chk($sformatf("v%0d status", i), int'(code_sync_status), int'(e.status));
            chk($sformatf("v%0d rx_even", i), int'(rx_even), int'(e.even));
            chk($sformatf("v%0d sudi_cg", i), int'(SUDI_code_group), int'(e.sudi));
            chk($sformatf("v%0d sudi_valid", i), int'(SUDI_valid), int'(e.valid));
            chk($sformatf("v%0d state", i), int'(dut.state), int'(e.st));
`ifdef SYNC_LOSS_CNT_EN
            chk($sformatf("v%0d loss_cnt", i), int'(loss_cnt), int'(e.loss));
`endif
        end

        // bounded wait for acquisition from reset on a plain /I2/ stream
        @(negedge GTX_CLK);
        mr_main_reset = 1'b1;
        signal_detect = 1'b1;
        @(negedge GTX_CLK);
        mr_main_reset = 1'b0;
        n = 0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            rx_code_group = (c % 2 == 0) ? K28_5_NEG : D16_2;
            @(posedge GTX_CLK);
            #1;
            if (code_sync_status) begin
                found = 1'b1;
                n = c + 1;
            end
            @(negedge GTX_CLK);
        end
        chk("acq found", int'(found), 1);
        chk("acq cycles", n, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
